// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 16x16 register file: init sweep after reset, then round-robin writeback arbitration.
// Optional macro REGFILE_R0_PROTECT_EN: RUN-phase writes to address 0 are granted but suppressed.
module regfile_write_arbiter #(
  parameter int              N_REQ      = 3,
  parameter int              AW         = 4,
  parameter int              DW         = 16,
  parameter logic [DW-1:0]   INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic                  rf_wEn,
  output logic [AW-1:0]         rf_rwAddr,
  output logic [DW-1:0]         rf_wData,
  output logic                  init_done,
  output logic                  busy
);

  localparam int              PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AW-1:0]   LAST_ADDR = {AW{1'b1}};
  localparam logic [PW-1:0]   PTR_RESET = PW'(N_REQ - 1);

  typedef enum logic {ST_INIT, ST_RUN} arbState;

  arbState          stateReg, stateNext;
  logic [AW-1:0]    initCntReg, initCntNext;
  logic [PW-1:0]    ptrReg, ptrNext;
  logic [N_REQ-1:0] gntReg, gntNext;
  logic             wEnReg, wEnNext;
  logic [AW-1:0]    addrReg, addrNext;
  logic [DW-1:0]    dataReg, dataNext;
  logic             initDoneReg, initDoneNext;
  logic             busyReg, busyNext;

  logic [AW-1:0]    reqAddrArr [N_REQ];
  logic [DW-1:0]    reqDataArr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gUnpack
      assign reqAddrArr[gi] = req_addr[gi*AW +: AW];
      assign reqDataArr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // A requester granted this cycle is masked so its follow-on write waits one cycle.
  logic [N_REQ-1:0] eligible;
  assign eligible = req & ~gntReg;

  logic             found;
  logic [PW-1:0]    winIdx;
  logic [PW-1:0]    candIdx;
  int               candSum;

  always_comb begin
    found   = 1'b0;
    winIdx  = ptrReg;
    candIdx = '0;
    candSum = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      candSum = int'(ptrReg) + k;
      if (candSum >= N_REQ) begin
        candSum = candSum - N_REQ;
      end
      candIdx = PW'(candSum);
      if (!found && eligible[candIdx]) begin
        found  = 1'b1;
        winIdx = candIdx;
      end
    end
  end

  logic [N_REQ-1:0] winOneHot;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gOneHot
      assign winOneHot[gi] = (winIdx == PW'(gi));
    end
  endgenerate

  logic [AW-1:0] winAddr;
  logic [DW-1:0] winData;
  logic          winWEn;

  assign winAddr = reqAddrArr[winIdx];
  assign winData = reqDataArr[winIdx];

`ifdef REGFILE_R0_PROTECT_EN
  // Register 0 behaves as a hard zero: the requester is still acknowledged.
  assign winWEn = (winAddr != '0);
`else
  assign winWEn = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= ST_INIT;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_INIT: if (initCntReg == LAST_ADDR) stateNext = ST_RUN;
      ST_RUN:  stateNext = ST_RUN;
      default: stateNext = ST_INIT;
    endcase
  end

  always_comb begin
    gntNext      = '0;
    wEnNext      = 1'b0;
    addrNext     = addrReg;
    dataNext     = dataReg;
    ptrNext      = ptrReg;
    initCntNext  = initCntReg;
    initDoneNext = (stateReg == ST_RUN);
    busyNext     = (stateReg == ST_INIT) | (|req);
    case (stateReg)
      ST_INIT: begin
        wEnNext     = 1'b1;
        addrNext    = initCntReg;
        dataNext    = INIT_VALUE;
        initCntNext = initCntReg + 1'b1;
      end
      ST_RUN: begin
        if (found) begin
          gntNext  = winOneHot;
          wEnNext  = winWEn;
          addrNext = winAddr;
          dataNext = winData;
          ptrNext  = winIdx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      initCntReg  <= '0;
      ptrReg      <= PTR_RESET;
      gntReg      <= '0;
      wEnReg      <= 1'b0;
      addrReg     <= '0;
      dataReg     <= '0;
      initDoneReg <= 1'b0;
      busyReg     <= 1'b1;
    end else begin
      initCntReg  <= initCntNext;
      ptrReg      <= ptrNext;
      gntReg      <= gntNext;
      wEnReg      <= wEnNext;
      addrReg     <= addrNext;
      dataReg     <= dataNext;
      initDoneReg <= initDoneNext;
      busyReg     <= busyNext;
    end
  end

  assign gnt       = gntReg;
  assign rf_wEn    = wEnReg;
  assign rf_rwAddr = addrReg;
  assign rf_wData  = dataReg;
  assign init_done = initDoneReg;
  assign busy      = busyReg;

  gntOneHot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gntReg));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a behavioural write-port model and a shadow register file.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            rf_wEn;
  logic [AW-1:0]   rf_rwAddr;
  logic [DW-1:0]   rf_wData;
  logic            init_done;
  logic            busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .INIT_VALUE(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .rf_wEn    (rf_wEn),
    .rf_rwAddr (rf_rwAddr),
    .rf_wData  (rf_wData),
    .init_done (init_done),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the visible outputs
  bit            mInit;
  int            mCnt;
  int            mLast;
  logic [N-1:0]  mGnt;
  logic          mWEn;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic          mInitDone;
  logic          mBusy;
  logic [DW-1:0] modelRf [16];
  logic [DW-1:0] dutRf   [16];
  int            wenCnt;
  int            gnt0Cnt;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mInit = 1'b1; mCnt = 0; mLast = N - 1;
    mGnt = '0; mWEn = 1'b0; mAddr = '0; mData = '0;
    mInitDone = 1'b0; mBusy = 1'b1;
  endtask

  // Predicts outputs after the next rising edge from the inputs currently applied.
  task automatic modelEdge();
    bit wasInit;
    int w;
    int i;
    wasInit   = mInit;
    mBusy     = wasInit || (req != '0);
    mInitDone = !wasInit;
    if (wasInit) begin
      mGnt  = '0;
      mWEn  = 1'b1;
      mAddr = mCnt[AW-1:0];
      mData = 16'h0000;
      mCnt++;
      if (mCnt == 16) mInit = 1'b0;
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        i = (mLast + k) % N;
        if (w < 0 && req[i] && !mGnt[i]) w = i;
      end
      mGnt = '0;
      if (w >= 0) begin
        mGnt[w] = 1'b1;
        mAddr   = req_addr[w*AW +: AW];
        mData   = req_data[w*DW +: DW];
        mLast   = w;
        mWEn    = 1'b1;
`ifdef REGFILE_R0_PROTECT_EN
        if (mAddr == '0) mWEn = 1'b0;
`endif
      end else begin
        mWEn = 1'b0;
      end
    end
    if (mWEn) modelRf[mAddr] = mData;
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    if (rf_wEn) dutRf[rf_rwAddr] = rf_wData;
    checkVal("gnt",       32'(gnt),       32'(mGnt));
    checkVal("rf_wEn",    32'(rf_wEn),    32'(mWEn));
    checkVal("rf_rwAddr", 32'(rf_rwAddr), 32'(mAddr));
    checkVal("rf_wData",  32'(rf_wData),  32'(mData));
    checkVal("init_done", 32'(init_done), 32'(mInitDone));
    checkVal("busy",      32'(busy),      32'(mBusy));
    if (gnt != '0)
      $display("txn t=%0t gnt=%b wEn=%0b addr=%0d data=%h", $time, gnt, rf_wEn, rf_rwAddr, rf_wData);
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_gnt"},       32'(gnt),       32'h0);
    checkVal({tag, "_wEn"},       32'(rf_wEn),    32'h0);
    checkVal({tag, "_addr"},      32'(rf_rwAddr), 32'h0);
    checkVal({tag, "_data"},      32'(rf_wData),  32'h0);
    checkVal({tag, "_init_done"}, 32'(init_done), 32'h0);
    checkVal({tag, "_busy"},      32'(busy),      32'h1);
  endtask

  task automatic newWrite(input int i);
    req[i]               = 1'b1;
    req_addr[i*AW +: AW] = AW'($urandom_range(15));
    req_data[i*DW +: DW] = DW'($urandom_range(16'hFFFF));
  endtask

  // Requesters obey the handshake: hold until granted, then drop or present the next write.
  task automatic driveAgents(input int pNew);
    for (int i = 0; i < N; i++) begin
      if (mGnt[i]) begin
        if (int'($urandom_range(99)) < pNew) newWrite(i);
        else req[i] = 1'b0;
      end else if (!req[i]) begin
        if (int'($urandom_range(99)) < pNew) newWrite(i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0;
    modelReset();
    for (int r = 0; r < 16; r++) begin
      modelRf[r] = '0;
      dutRf[r]   = '0;
    end
    #12;
    checkReset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Init with all requesters asserted, aborted at address 7
    for (int i = 0; i < N; i++) newWrite(i);
    repeat (8) step();
    #2 rst_n = 1'b0;
    #1;
    checkReset("midinit");
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full init sweep, requests ignored
    wenCnt = 0;
    repeat (16) begin
      step();
      wenCnt += int'(rf_wEn);
    end
    checkVal("init_wen_cycles", 32'(wenCnt), 32'd16);

    // Full contention, every granted requester immediately presents a new write
    repeat (12) begin
      driveAgents(100);
      step();
    end
    req = '0;
    repeat (2) step();

    // Single request
    req = 3'b010;
    req_addr[1*AW +: AW] = 4'd5;
    req_data[1*DW +: DW] = 16'h00A5;
    step();
    checkVal("single_gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    checkVal("r5_read", 32'(dutRf[5]), 32'h00A5);

    // One requester held alone for four cycles
    gnt0Cnt = 0;
    req = 3'b001;
    req_addr[0 +: AW] = 4'd3;
    req_data[0 +: DW] = 16'h1234;
    repeat (4) begin
      step();
      gnt0Cnt += int'(gnt[0]);
    end
    checkVal("b2b_gnt0_count", 32'(gnt0Cnt), 32'd2);
    req = '0;
    step();

    // Write aimed at register 0
    req = 3'b010;
    req_addr[1*AW +: AW] = 4'd0;
    req_data[1*DW +: DW] = 16'hFFFF;
    step();
    checkVal("r0_gnt", 32'(gnt), 32'h2);
`ifdef REGFILE_R0_PROTECT_EN
    checkVal("r0_wEn", 32'(rf_wEn), 32'h0);
`else
    checkVal("r0_wEn", 32'(rf_wEn), 32'h1);
`endif
    req = '0;
    step();
`ifdef REGFILE_R0_PROTECT_EN
    checkVal("r0_read", 32'(dutRf[0]), 32'h0000);
`else
    checkVal("r0_read", 32'(dutRf[0]), 32'hFFFF);
`endif

    // Random traffic
    repeat (300) begin
      driveAgents(40);
      step();
    end
    req = '0;
    repeat (2) step();

    for (int r = 0; r < 16; r++) begin
      checkVal($sformatf("rf_r%0d", r), 32'(dutRf[r]), 32'(modelRf[r]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (wEn/rwAddr/wData) of the 16x16-bit register file, which has 4-bit addresses.
- After reset it runs an init sequencer that writes INIT_VALUE to all 16 registers.
- It then shares the write port among N_REQ writeback requesters (ALU result, load data, debug loader) using round-robin arbitration and a one-cycle grant handshake.
- It sits between the datapath writeback sources and the register file, clocked on the register file's main clk.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- AW, 4, register address width (16 registers).
- DW, 16, register data width.
- INIT_VALUE, 16'h0000, value written to every register during init.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester write request.
- req_addr  input  N_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_data  input  N_REQ*DW  packed data; requester i uses bits [i*DW +: DW].
- gnt  output  N_REQ  one-hot grant pulse, one cycle.
- rf_wEn  output  1  register file write enable.
- rf_rwAddr  output  AW  register file write address.
- rf_wData  output  DW  register file write data.
- init_done  output  1  high once init has completed.
- busy  output  1  high while in INIT, or while any req is pending.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, rf_wEn=0, rf_rwAddr=0, rf_wData=0, init_done=0, busy=1. State=INIT, init counter=0, round-robin pointer=N_REQ-1, so requester 0 has first priority.
- States: INIT, RUN.
- INIT, per cycle: rf_wEn=1, rf_rwAddr=counter, rf_wData=INIT_VALUE, then counter+1.
  - Addresses 0..15 are written on 16 consecutive cycles.
  - The write of address 15 goes to RUN; init_done=1 from the next cycle.
  - gnt stays 0 throughout INIT, and req is ignored.
- Reset asserted mid-INIT aborts the sequence; init restarts at address 0 after release.
- RUN, each rising edge:
  - Form eligible = req & ~gnt. A requester granted in the current cycle is masked.
  - Select the first eligible index searching from ptr+1 upward, wrapping mod N_REQ.
  - If one is found (winner w): next cycle gnt[w]=1, rf_wEn=1, rf_rwAddr/rf_wData = requester w's addr/data sampled at that edge, ptr=w.
  - If none is found: gnt=0, rf_wEn=0, address/data hold their last values, ptr unchanged.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt[i]=1.
  - In the gnt cycle the requester may drop req, or present the next write. That next write becomes eligible one cycle later.
  - Latency from req rise to write cycle is 1 cycle minimum; worst case is N_REQ cycles under full contention.
  - One write per cycle, so port throughput is 1.
- Simultaneous requests: exactly one winner per cycle, in round-robin order. Starvation-free; each requester waits at most N_REQ-1 writes.
- Same address from two requesters on consecutive grants: both writes occur in grant order, and the last write wins.
- busy = (state==INIT) | (|req).

Optional Feature:
- Macro: REGFILE_R0_PROTECT_EN.
- When defined, in RUN:
  - A winning request to address 0 still receives its gnt pulse.
  - rf_wEn stays 0 for that cycle, so register 0 holds INIT_VALUE (MIPS $zero).
  - INIT still writes address 0.
- When undefined, address 0 is written like any other register.

Test Plan:
- Init sequence: release rst_n -> rf_wEn=1 for exactly 16 cycles with rf_rwAddr 0..15 and rf_wData=16'h0000; init_done=1 on cycle 17; gnt stays 0 even with req=3'b111 held during INIT.
- Single request: req=3'b010, addr=4'd5, data=16'h00A5 -> next cycle gnt=3'b010, rf_wEn=1, rf_rwAddr=5, rf_wData=16'h00A5; gnt is a one-cycle pulse; a register file read of r5 returns 16'h00A5.
- Full contention: req=3'b111 held continuously -> grants in order 001, 010, 100, 001, ..., one per cycle, each write carrying its own requester's addr/data.
- Back-to-back from one requester: req0 held high, alone, for 4 cycles -> gnt0 on cycles 1 and 3 only (masked in the cycle after each grant).
- Reset mid-INIT: assert rst_n=0 at init address 7 -> outputs return to reset values at once (async); after release, init restarts from address 0.
- With REGFILE_R0_PROTECT_EN: req1 addr=0, data=16'hFFFF -> gnt=3'b010 but rf_wEn=0, and r0 reads 16'h0000. Without the macro: rf_wEn=1 and r0 reads 16'hFFFF.
